// File: rtl/pkg_drop_recycler.sv
// pkg_drop_recycler: drop-path buffer manager for a 4-port switch.
// It owns the free block-address pool, the block link-list RAM and a drop engine.
// The drop engine walks a dropped packet's link list and returns every block to the pool.
// Ports:
//   iClk, iRst_n                        clock, synchronous active-low reset
//   iWriteLaddr/Ldata/LaddrVld          link RAM write (current block -> next block)
//   iEptyAddrRdy, oEptyAddr(Vld)        free-address pop interface (show-ahead)
//   iPkgFirAddrN/VldN/BlockNumN/DropN   per-port drop request (N = 0..3)
//   oPkgFirAddrRdyN                     per-port holding register empty
//   oDropRcvrAddr(Vld)                  recycled address strobe, one per block
//   oFull, oAlmostFull                  free-pool level flags
module pkg_drop_recycler #(
  parameter int unsigned ADDR_LENTH = 12,
  parameter int unsigned BLKNUM_W   = 4,
  parameter int unsigned ALMOST_TH  = 16
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [ADDR_LENTH-1:0] iWriteLaddr,
  input  logic [ADDR_LENTH-1:0] iWriteLdata,
  input  logic                  iWriteLaddrVld,
  input  logic                  iEptyAddrRdy,
  output logic [ADDR_LENTH-1:0] oEptyAddr,
  output logic                  oEptyAddrVld,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr0,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr1,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr2,
  input  logic [ADDR_LENTH-1:0] iPkgFirAddr3,
  input  logic                  iPkgFirAddrVld0,
  input  logic                  iPkgFirAddrVld1,
  input  logic                  iPkgFirAddrVld2,
  input  logic                  iPkgFirAddrVld3,
  input  logic [BLKNUM_W-1:0]   iPkgBlockNum0,
  input  logic [BLKNUM_W-1:0]   iPkgBlockNum1,
  input  logic [BLKNUM_W-1:0]   iPkgBlockNum2,
  input  logic [BLKNUM_W-1:0]   iPkgBlockNum3,
  input  logic                  iPkgDrop0,
  input  logic                  iPkgDrop1,
  input  logic                  iPkgDrop2,
  input  logic                  iPkgDrop3,
  output logic                  oPkgFirAddrRdy0,
  output logic                  oPkgFirAddrRdy1,
  output logic                  oPkgFirAddrRdy2,
  output logic                  oPkgFirAddrRdy3,
  output logic [ADDR_LENTH-1:0] oDropRcvrAddr,
  output logic                  oDropRcvrAddrVld,
  output logic                  oFull,
  output logic                  oAlmostFull
);
  localparam int unsigned DEPTH  = 1 << ADDR_LENTH;
  localparam int unsigned CNT_W  = ADDR_LENTH + 1;
  localparam int unsigned NPORT  = 4;
  localparam int unsigned PORT_W = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_RECYCLE, ST_NEXT} stateT;

  stateT state, stateNext;

  logic [ADDR_LENTH-1:0] reqFirst [NPORT];
  logic [BLKNUM_W-1:0]   reqNum   [NPORT];
  logic [NPORT-1:0]      reqVld, reqDrop, capture;

  logic [NPORT-1:0]      holdVld;
  logic [ADDR_LENTH-1:0] holdFirst [NPORT];
  logic [BLKNUM_W-1:0]   holdNum   [NPORT];

  logic [PORT_W-1:0]     rrPtr, grantPort, arbIdx, curPort;
  logic                  grantVld;
  logic [BLKNUM_W-1:0]   remCnt;
  logic                  doGrant, doRecycle, doNext, lastBlk;

  logic [ADDR_LENTH-1:0] linkRam [DEPTH];
  logic [ADDR_LENTH-1:0] linkRdData;

  logic [ADDR_LENTH-1:0] fifoMem [DEPTH];
  logic [ADDR_LENTH-1:0] fifoRdPtr, fifoWrPtr;
  logic [CNT_W-1:0]      fifoCnt, initCnt, freeCnt, freeNext;
  logic                  initLeft, popEn, popInit, popFifo, pushEn;

  // Gather the per-port request pins into arrays
  assign reqFirst[0] = iPkgFirAddr0;
  assign reqFirst[1] = iPkgFirAddr1;
  assign reqFirst[2] = iPkgFirAddr2;
  assign reqFirst[3] = iPkgFirAddr3;
  assign reqNum[0]   = iPkgBlockNum0;
  assign reqNum[1]   = iPkgBlockNum1;
  assign reqNum[2]   = iPkgBlockNum2;
  assign reqNum[3]   = iPkgBlockNum3;
  assign reqVld      = {iPkgFirAddrVld3, iPkgFirAddrVld2, iPkgFirAddrVld1, iPkgFirAddrVld0};
  assign reqDrop     = {iPkgDrop3, iPkgDrop2, iPkgDrop1, iPkgDrop0};

  // Non-drop requests are acknowledged by Rdy but never stored
  assign capture = reqVld & reqDrop & ~holdVld;

  assign oPkgFirAddrRdy0 = ~holdVld[0];
  assign oPkgFirAddrRdy1 = ~holdVld[1];
  assign oPkgFirAddrRdy2 = ~holdVld[2];
  assign oPkgFirAddrRdy3 = ~holdVld[3];

  // Round-robin pick among pending ports starting at rrPtr
  always_comb begin
    grantVld  = 1'b0;
    grantPort = rrPtr;
    arbIdx    = rrPtr;
    for (int i = 0; i < NPORT; i++) begin
      arbIdx = rrPtr + PORT_W'(i);
      if (!grantVld && holdVld[arbIdx]) begin
        grantVld  = 1'b1;
        grantPort = arbIdx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= ST_IDLE;
    else         state <= stateNext;
  end

  // FSM next state
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:    if (grantVld) stateNext = ST_RECYCLE;
      ST_RECYCLE: stateNext = (remCnt == '0) ? ST_IDLE : ST_NEXT;
      ST_NEXT:    stateNext = ST_RECYCLE;
      default:    stateNext = ST_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    doGrant   = 1'b0;
    doRecycle = 1'b0;
    doNext    = 1'b0;
    lastBlk   = 1'b0;
    case (state)
      ST_IDLE:    doGrant = grantVld;
      ST_RECYCLE: begin
        doRecycle = 1'b1;
        lastBlk   = (remCnt == '0);
      end
      ST_NEXT:    doNext = 1'b1;
      default:    ;
    endcase
  end

  // Walk datapath: oDropRcvrAddr doubles as the current-block register
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oDropRcvrAddr    <= '0;
      oDropRcvrAddrVld <= 1'b0;
      remCnt           <= '0;
      curPort          <= '0;
      rrPtr            <= '0;
      holdVld          <= '0;
    end else begin
      oDropRcvrAddrVld <= (stateNext == ST_RECYCLE);
      if (doGrant) begin
        oDropRcvrAddr <= holdFirst[grantPort];
        remCnt        <= holdNum[grantPort];
        curPort       <= grantPort;
        rrPtr         <= grantPort + PORT_W'(1);
      end else if (doNext) begin
        oDropRcvrAddr <= linkRdData;
        remCnt        <= remCnt - BLKNUM_W'(1);
      end
      for (int p = 0; p < NPORT; p++) begin
        if (lastBlk && curPort == PORT_W'(p)) holdVld[p] <= 1'b0;
        else if (capture[p])                  holdVld[p] <= 1'b1;
      end
    end
  end

  // Holding register payload
  always_ff @(posedge iClk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (capture[p]) begin
        holdFirst[p] <= reqFirst[p];
        holdNum[p]   <= reqNum[p];
      end
    end
  end

  // Link RAM: synchronous read of the block being recycled, read-before-write
  always_ff @(posedge iClk) begin
    if (iWriteLaddrVld) linkRam[iWriteLaddr] <= iWriteLdata;
    linkRdData <= linkRam[oDropRcvrAddr];
  end

  // Free pool: init counter first, then the recycle FIFO
  assign initLeft  = (initCnt != CNT_W'(DEPTH));
  assign freeCnt   = CNT_W'(DEPTH) - initCnt + fifoCnt;
  assign popEn     = oEptyAddrVld & iEptyAddrRdy;
  assign popInit   = popEn & initLeft;
  assign popFifo   = popEn & ~initLeft;
  assign pushEn    = doRecycle & (freeCnt != CNT_W'(DEPTH));
  assign freeNext  = freeCnt - CNT_W'(popEn) + CNT_W'(pushEn);
  assign oEptyAddr = initLeft ? initCnt[ADDR_LENTH-1:0] : fifoMem[fifoRdPtr];

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      initCnt      <= '0;
      fifoRdPtr    <= '0;
      fifoWrPtr    <= '0;
      fifoCnt      <= '0;
      oEptyAddrVld <= 1'b1;
      oFull        <= 1'b0;
      oAlmostFull  <= 1'b0;
    end else begin
      if (popInit) initCnt   <= initCnt + CNT_W'(1);
      if (popFifo) fifoRdPtr <= fifoRdPtr + ADDR_LENTH'(1);
      if (pushEn)  fifoWrPtr <= fifoWrPtr + ADDR_LENTH'(1);
      fifoCnt      <= fifoCnt + CNT_W'(pushEn) - CNT_W'(popFifo);
      oEptyAddrVld <= (freeNext != '0);
      oFull        <= (freeNext == '0);
      oAlmostFull  <= (freeNext <= CNT_W'(ALMOST_TH));
    end
  end

  always_ff @(posedge iClk) begin
    if (pushEn) fifoMem[fifoWrPtr] <= oDropRcvrAddr;
  end

endmodule

// File: tb/tb_pkg_drop_recycler.sv
// Directed bench for pkg_drop_recycler: free pool, drop walks, arbitration, reset.
module tb_pkg_drop_recycler;
  localparam int unsigned AW = 12;
  localparam int unsigned NW = 4;

  logic          iClk, iRst_n;
  logic [AW-1:0] iWriteLaddr, iWriteLdata;
  logic          iWriteLaddrVld, iEptyAddrRdy;
  logic [AW-1:0] oEptyAddr;
  logic          oEptyAddrVld;
  logic [AW-1:0] iPkgFirAddr0, iPkgFirAddr1, iPkgFirAddr2, iPkgFirAddr3;
  logic          iPkgFirAddrVld0, iPkgFirAddrVld1, iPkgFirAddrVld2, iPkgFirAddrVld3;
  logic [NW-1:0] iPkgBlockNum0, iPkgBlockNum1, iPkgBlockNum2, iPkgBlockNum3;
  logic          iPkgDrop0, iPkgDrop1, iPkgDrop2, iPkgDrop3;
  logic          oPkgFirAddrRdy0, oPkgFirAddrRdy1, oPkgFirAddrRdy2, oPkgFirAddrRdy3;
  logic [AW-1:0] oDropRcvrAddr;
  logic          oDropRcvrAddrVld, oFull, oAlmostFull;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int strobeAddr[$];
  int strobeCyc[$];
  int expAddr[$];
  int c0, doneCyc, n;

  pkg_drop_recycler dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iWriteLaddr(iWriteLaddr), .iWriteLdata(iWriteLdata), .iWriteLaddrVld(iWriteLaddrVld),
    .iEptyAddrRdy(iEptyAddrRdy), .oEptyAddr(oEptyAddr), .oEptyAddrVld(oEptyAddrVld),
    .iPkgFirAddr0(iPkgFirAddr0), .iPkgFirAddr1(iPkgFirAddr1),
    .iPkgFirAddr2(iPkgFirAddr2), .iPkgFirAddr3(iPkgFirAddr3),
    .iPkgFirAddrVld0(iPkgFirAddrVld0), .iPkgFirAddrVld1(iPkgFirAddrVld1),
    .iPkgFirAddrVld2(iPkgFirAddrVld2), .iPkgFirAddrVld3(iPkgFirAddrVld3),
    .iPkgBlockNum0(iPkgBlockNum0), .iPkgBlockNum1(iPkgBlockNum1),
    .iPkgBlockNum2(iPkgBlockNum2), .iPkgBlockNum3(iPkgBlockNum3),
    .iPkgDrop0(iPkgDrop0), .iPkgDrop1(iPkgDrop1), .iPkgDrop2(iPkgDrop2), .iPkgDrop3(iPkgDrop3),
    .oPkgFirAddrRdy0(oPkgFirAddrRdy0), .oPkgFirAddrRdy1(oPkgFirAddrRdy1),
    .oPkgFirAddrRdy2(oPkgFirAddrRdy2), .oPkgFirAddrRdy3(oPkgFirAddrRdy3),
    .oDropRcvrAddr(oDropRcvrAddr), .oDropRcvrAddrVld(oDropRcvrAddrVld),
    .oFull(oFull), .oAlmostFull(oAlmostFull)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // Record every recycle strobe with the cycle it was seen in
  always @(negedge iClk) begin
    if (oDropRcvrAddrVld === 1'b1) begin
      strobeAddr.push_back(int'(oDropRcvrAddr));
      strobeCyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clearStrobes();
    strobeAddr.delete();
    strobeCyc.delete();
  endtask

  function automatic logic [3:0] allRdy();
    return {oPkgFirAddrRdy3, oPkgFirAddrRdy2, oPkgFirAddrRdy1, oPkgFirAddrRdy0};
  endfunction

  task automatic setReq(input int port, input int first, input int num, input logic drop);
    case (port)
      0: begin iPkgFirAddr0 = AW'(first); iPkgBlockNum0 = NW'(num); iPkgDrop0 = drop; iPkgFirAddrVld0 = 1'b1; end
      1: begin iPkgFirAddr1 = AW'(first); iPkgBlockNum1 = NW'(num); iPkgDrop1 = drop; iPkgFirAddrVld1 = 1'b1; end
      2: begin iPkgFirAddr2 = AW'(first); iPkgBlockNum2 = NW'(num); iPkgDrop2 = drop; iPkgFirAddrVld2 = 1'b1; end
      default: begin iPkgFirAddr3 = AW'(first); iPkgBlockNum3 = NW'(num); iPkgDrop3 = drop; iPkgFirAddrVld3 = 1'b1; end
    endcase
  endtask

  task automatic clearReq();
    iPkgFirAddrVld0 = 1'b0; iPkgFirAddrVld1 = 1'b0; iPkgFirAddrVld2 = 1'b0; iPkgFirAddrVld3 = 1'b0;
    iPkgDrop0 = 1'b0; iPkgDrop1 = 1'b0; iPkgDrop2 = 1'b0; iPkgDrop3 = 1'b0;
  endtask

  task automatic writeLink(input int a, input int d);
    iWriteLaddr    = AW'(a);
    iWriteLdata    = AW'(d);
    iWriteLaddrVld = 1'b1;
    tick();
    iWriteLaddrVld = 1'b0;
  endtask

  task automatic resetDut();
    iRst_n = 1'b0;
    tick();
    tick();
    iRst_n = 1'b1;
    clearStrobes();
  endtask

  initial begin
    iRst_n = 1'b0; iWriteLaddr = '0; iWriteLdata = '0; iWriteLaddrVld = 1'b0; iEptyAddrRdy = 1'b0;
    iPkgFirAddr0 = '0; iPkgFirAddr1 = '0; iPkgFirAddr2 = '0; iPkgFirAddr3 = '0;
    iPkgBlockNum0 = '0; iPkgBlockNum1 = '0; iPkgBlockNum2 = '0; iPkgBlockNum3 = '0;
    clearReq();

    // Reset state
    resetDut();
    chk("rst_rdy", 32'(allRdy()), 32'hF);
    chk("rst_strobe", 32'(oDropRcvrAddrVld), 0);
    chk("rst_epty_vld", 32'(oEptyAddrVld), 1);
    chk("rst_epty_addr", 32'(oEptyAddr), 0);
    chk("rst_full", 32'(oFull), 0);
    chk("rst_afull", 32'(oAlmostFull), 0);

    // Pop three addresses from the init counter
    iEptyAddrRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_addr", 32'(oEptyAddr), 32'(i));
      tick();
    end
    iEptyAddrRdy = 1'b0;
    chk("t1_next_addr", 32'(oEptyAddr), 3);
    chk("t1_full", 32'(oFull), 0);

    // Pop through 10, build link lists, drop 1/9 on port 0
    iEptyAddrRdy = 1'b1;
    for (int i = 3; i <= 10; i++) begin
      chk("t2_pop_addr", 32'(oEptyAddr), 32'(i));
      tick();
    end
    iEptyAddrRdy = 1'b0;
    for (int k = 1; k <= 9; k++)   writeLink(k, k + 1);
    for (int k = 20; k <= 29; k++) writeLink(k, k + 1);
    for (int k = 35; k <= 49; k++) writeLink(k, k + 1);
    clearStrobes();
    setReq(0, 1, 9, 1'b1);
    tick();
    c0 = cyc;
    clearReq();
    chk("t2_rdy_low", 32'(oPkgFirAddrRdy0), 0);
    for (int k = 0; k < 100 && oPkgFirAddrRdy0 !== 1'b1; k++) tick();
    doneCyc = cyc;
    chk("t2_rdy_back", 32'(oPkgFirAddrRdy0), 1);
    chk("t2_strobe_cnt", 32'(strobeAddr.size()), 10);
    n = (strobeAddr.size() < 10) ? strobeAddr.size() : 10;
    for (int i = 0; i < n; i++) begin
      chk("t2_strobe_addr", 32'(strobeAddr[i]), 32'(i + 1));
      chk("t2_strobe_cyc", 32'(strobeCyc[i] - c0), 32'(1 + 2 * i));
    end
    chk("t2_rdy_cyc", 32'(doneCyc - c0), 20);

    // Four simultaneous drops, served 0,1,2,3 with links left from before reset
    resetDut();
    setReq(0, 1, 9, 1'b1);
    setReq(1, 20, 10, 1'b1);
    setReq(2, 35, 15, 1'b1);
    setReq(3, 70, 0, 1'b1);
    tick();
    c0 = cyc;
    clearReq();
    for (int k = 0; k < 200 && allRdy() !== 4'hF; k++) tick();
    chk("t3_all_rdy", 32'(allRdy()), 32'hF);
    expAddr.delete();
    for (int a = 1; a <= 10; a++)  expAddr.push_back(a);
    for (int a = 20; a <= 30; a++) expAddr.push_back(a);
    for (int a = 35; a <= 50; a++) expAddr.push_back(a);
    expAddr.push_back(70);
    chk("t3_strobe_cnt", 32'(strobeAddr.size()), 38);
    n = (strobeAddr.size() < 38) ? strobeAddr.size() : 38;
    for (int i = 0; i < n; i++) begin
      chk("t3_strobe_addr", 32'(strobeAddr[i]), 32'(expAddr[i]));
      chk("t3_strobe_cyc", 32'(strobeCyc[i] - c0), 32'(1 + 2 * i));
    end
    chk("t3_pool_head", 32'(oEptyAddr), 0);

    // Drain the whole pool, then recycle one block back into it
    iEptyAddrRdy = 1'b1;
    for (int k = 1; k <= 4096; k++) begin
      tick();
      if (k == 4079) chk("t4_afull_17", 32'(oAlmostFull), 0);
      if (k == 4080) chk("t4_afull_16", 32'(oAlmostFull), 1);
      if (k == 4095) begin
        chk("t4_full_1left", 32'(oFull), 0);
        chk("t4_vld_1left", 32'(oEptyAddrVld), 1);
        chk("t4_addr_1left", 32'(oEptyAddr), 4095);
      end
    end
    chk("t4_full", 32'(oFull), 1);
    chk("t4_epty_vld", 32'(oEptyAddrVld), 0);
    tick();
    iEptyAddrRdy = 1'b0;
    chk("t4_full_hold", 32'(oFull), 1);
    clearStrobes();
    setReq(0, 70, 0, 1'b1);
    tick();
    clearReq();
    tick();
    chk("t4_strobe_vld", 32'(oDropRcvrAddrVld), 1);
    chk("t4_strobe_addr", 32'(oDropRcvrAddr), 70);
    chk("t4_vld_before_push", 32'(oEptyAddrVld), 0);
    tick();
    chk("t4_vld_after_push", 32'(oEptyAddrVld), 1);
    chk("t4_addr_after_push", 32'(oEptyAddr), 70);
    chk("t4_full_after_push", 32'(oFull), 0);
    chk("t4_rdy0", 32'(oPkgFirAddrRdy0), 1);
    iEptyAddrRdy = 1'b1;
    tick();
    iEptyAddrRdy = 1'b0;
    chk("t4_full_again", 32'(oFull), 1);
    chk("t4_vld_again", 32'(oEptyAddrVld), 0);

    // Non-drop request is acknowledged and discarded
    clearStrobes();
    setReq(0, 5, 3, 1'b0);
    tick();
    clearReq();
    chk("t5_rdy_stays", 32'(oPkgFirAddrRdy0), 1);
    for (int k = 0; k < 10; k++) tick();
    chk("t5_no_strobe", 32'(strobeAddr.size()), 0);

    // Reset in the middle of a walk
    clearStrobes();
    setReq(1, 20, 10, 1'b1);
    tick();
    clearReq();
    for (int k = 0; k < 50 && strobeAddr.size() < 3; k++) tick();
    chk("t6_walk_started", 32'(strobeAddr.size() >= 3), 1);
    iRst_n = 1'b0;
    tick();
    iRst_n = 1'b1;
    clearStrobes();
    for (int k = 0; k < 30; k++) tick();
    chk("t6_no_strobe", 32'(strobeAddr.size()), 0);
    chk("t6_all_rdy", 32'(allRdy()), 32'hF);
    chk("t6_epty_vld", 32'(oEptyAddrVld), 1);
    chk("t6_epty_addr", 32'(oEptyAddr), 0);
    chk("t6_full", 32'(oFull), 0);
    chk("t6_afull", 32'(oAlmostFull), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
